// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the memory-stage SRAM controller.
package mem_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOW,
      ST_HIGH,
      ST_DONE
   } state_e;

   localparam logic [31:0] DATA_BASE_DEF = 32'd1024;
   localparam int unsigned SRAM_AW       = 18;
   localparam int unsigned SRAM_DW       = 16;
   localparam int unsigned WORD_IDX_W    = SRAM_AW - 1;

endpackage

// File: rtl/sram_wait_counter.sv
// Loadable down-counter that times each SRAM half-access; done_o is high on the final cycle.
module sram_wait_counter #(
   parameter int unsigned WAIT_CYCLES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic load_i,
   output logic done_o
);

   localparam int unsigned CW = $clog2(WAIT_CYCLES + 1);

   logic [CW-1:0] count_q;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= '0;
      end else if (load_i) begin
         count_q <= CW'(WAIT_CYCLES - 1);
      end else if (count_q != '0) begin
         count_q <= count_q - CW'(1);
      end
   end

   assign done_o = (count_q == '0);

endmodule

// File: rtl/sram_mem_controller.sv
// Memory-stage controller: each 32-bit LDR/STR becomes two 16-bit SRAM half-accesses.
// Optional bounds checking and the addr_err port are compiled in with SRAM_BOUNDS_CHECK_EN.
module sram_mem_controller
   import mem_ctrl_pkg::*;
#(
   parameter int unsigned WAIT_CYCLES = 2,
   parameter logic [31:0] DATA_BASE   = DATA_BASE_DEF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               rd_en,
   input  logic               wr_en,
   input  logic [31:0]        address,
   input  logic [31:0]        write_data,
   output logic [31:0]        read_data,
   output logic               ready,
   output logic [SRAM_AW-1:0] sram_addr,
   input  logic [SRAM_DW-1:0] sram_dq_in,
   output logic [SRAM_DW-1:0] sram_dq_out,
   output logic               sram_dq_oe,
`ifdef SRAM_BOUNDS_CHECK_EN
   output logic               addr_err,
`endif
   output logic               sram_we_n
);

   state_e                 state_q;
   logic [WORD_IDX_W-1:0]  idx_q;
   logic [SRAM_DW-1:0]     wdata_hi_q;
   logic [SRAM_DW-1:0]     rd_lo_q;
   logic [31:0]            read_data_q;
   logic                   is_wr_q;
   logic                   we_n_q;
   logic                   oe_q;
   logic [SRAM_AW-1:0]     addr_q;
   logic [SRAM_DW-1:0]     dq_out_q;

   logic                   req;
   logic                   req_err;
   logic                   cnt_load;
   logic                   cnt_done;
   logic [WORD_IDX_W-1:0]  word_idx;

   assign req      = rd_en | wr_en;
   assign word_idx = WORD_IDX_W'((address - DATA_BASE) >> 2);

`ifdef SRAM_BOUNDS_CHECK_EN
   logic err_q;

   assign req_err  = (address < DATA_BASE) || (address[1:0] != 2'b00) ||
                     (((address - DATA_BASE) >> (WORD_IDX_W + 2)) != 32'd0);
   assign addr_err = err_q;
`else
   assign req_err  = 1'b0;
`endif

   assign cnt_load = ((state_q == ST_IDLE) && req && !req_err) ||
                     ((state_q == ST_LOW) && cnt_done);

   sram_wait_counter #(.WAIT_CYCLES(WAIT_CYCLES)) u_wait (
      .clk    (clk),
      .rst    (rst),
      .load_i (cnt_load),
      .done_o (cnt_done)
   );

   // NOTE: every register, including the captured read word, is asynchronously reset so an aborted access leaves no stale strobe.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         idx_q       <= '0;
         wdata_hi_q  <= '0;
         rd_lo_q     <= '0;
         read_data_q <= '0;
         is_wr_q     <= 1'b0;
         we_n_q      <= 1'b1;
         oe_q        <= 1'b0;
         addr_q      <= '0;
         dq_out_q    <= '0;
`ifdef SRAM_BOUNDS_CHECK_EN
         err_q       <= 1'b0;
`endif
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (req) begin
                  idx_q      <= word_idx;
                  wdata_hi_q <= write_data[31:16];
                  is_wr_q    <= wr_en;
                  if (req_err) begin
                     state_q <= ST_DONE;
`ifdef SRAM_BOUNDS_CHECK_EN
                     err_q   <= 1'b1;
`endif
                  end else begin
                     // Bus outputs are set up on entry so they are valid for the whole LOW phase.
                     state_q  <= ST_LOW;
                     addr_q   <= {word_idx, 1'b0};
                     dq_out_q <= write_data[15:0];
                     we_n_q   <= ~wr_en;
                     oe_q     <= wr_en;
                  end
               end
            end
            ST_LOW: begin
               if (cnt_done) begin
                  if (!is_wr_q) rd_lo_q <= sram_dq_in;
                  state_q  <= ST_HIGH;
                  addr_q   <= {idx_q, 1'b1};
                  dq_out_q <= wdata_hi_q;
               end
            end
            ST_HIGH: begin
               if (cnt_done) begin
                  // The full word is published at once so read_data never shows a half-updated value.
                  if (!is_wr_q) read_data_q <= {sram_dq_in, rd_lo_q};
                  state_q <= ST_DONE;
                  we_n_q  <= 1'b1;
                  oe_q    <= 1'b0;
               end
            end
            ST_DONE: begin
               state_q <= ST_IDLE;
`ifdef SRAM_BOUNDS_CHECK_EN
               err_q   <= 1'b0;
`endif
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign ready       = ~req | (state_q == ST_DONE);
   assign read_data   = read_data_q;
   assign sram_addr   = addr_q;
   assign sram_dq_out = dq_out_q;
   assign sram_dq_oe  = oe_q;
   assign sram_we_n   = we_n_q;

endmodule

// File: tb/tb_sram_mem_controller.sv
// Directed, table-driven bench for sram_mem_controller with a behavioural 16-bit SRAM model.
module tb_sram_mem_controller;

   localparam int W = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        rd_en;
   logic        wr_en;
   logic [31:0] address;
   logic [31:0] write_data;
   logic [31:0] read_data;
   logic        ready;
   logic [17:0] sram_addr;
   logic [15:0] sram_dq_in;
   logic [15:0] sram_dq_out;
   logic        sram_dq_oe;
   logic        sram_we_n;
`ifdef SRAM_BOUNDS_CHECK_EN
   logic        addr_err;
`endif

   int n_vec = 0;
   int n_err = 0;

   typedef struct {
      logic        rd;
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [16:0] idx;
      logic [31:0] exp_rd;
   } vec_t;

   vec_t vecs[$];

   logic [15:0] mem [64] = '{default: 16'h0000};

   always #5 clk = ~clk;

   assign sram_dq_in = mem[sram_addr[5:0]];

   always @(posedge clk) begin
      if (!sram_we_n) mem[sram_addr[5:0]] <= sram_dq_out;
   end

   sram_mem_controller #(.WAIT_CYCLES(W), .DATA_BASE(32'd1024)) dut (
      .clk         (clk),
      .rst         (rst),
      .rd_en       (rd_en),
      .wr_en       (wr_en),
      .address     (address),
      .write_data  (write_data),
      .read_data   (read_data),
      .ready       (ready),
      .sram_addr   (sram_addr),
      .sram_dq_in  (sram_dq_in),
      .sram_dq_out (sram_dq_out),
      .sram_dq_oe  (sram_dq_oe),
`ifdef SRAM_BOUNDS_CHECK_EN
      .addr_err    (addr_err),
`endif
      .sram_we_n   (sram_we_n)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // Called just after a rising edge with the DUT idle; returns just after a rising edge, idle again.
   task automatic run_vec(input vec_t v);
      logic        half;
      logic [15:0] exp_dq;
      rd_en      = v.rd;
      wr_en      = v.wr;
      address    = v.addr;
      write_data = v.wdata;
      @(negedge clk);
      check("req_ready_low", {31'd0, ready}, 32'd0);
      for (int c = 1; c <= 2 * W + 1; c++) begin
         @(posedge clk);
         @(negedge clk);
         if (c <= 2 * W) begin
            half   = (c > W);
            exp_dq = half ? v.wdata[31:16] : v.wdata[15:0];
            check("busy_ready", {31'd0, ready}, 32'd0);
            check("sram_addr", {14'd0, sram_addr}, {14'd0, v.idx, half});
            check("we_n", {31'd0, sram_we_n}, {31'd0, ~v.wr});
            check("dq_oe", {31'd0, sram_dq_oe}, {31'd0, v.wr});
            if (v.wr) check("dq_out", {16'd0, sram_dq_out}, {16'd0, exp_dq});
         end else begin
            check("done_ready", {31'd0, ready}, 32'd1);
            check("done_we_n", {31'd0, sram_we_n}, 32'd1);
            check("done_oe", {31'd0, sram_dq_oe}, 32'd0);
            check("read_data", read_data, v.exp_rd);
            rd_en = 1'b0;
            wr_en = 1'b0;
         end
      end
      @(posedge clk);
      #1;
      check("idle_ready", {31'd0, ready}, 32'd1);
   endtask

   initial begin
      rst        = 1'b1;
      rd_en      = 1'b0;
      wr_en      = 1'b0;
      address    = 32'd0;
      write_data = 32'd0;

      vecs.push_back('{1'b0, 1'b1, 32'd1028, 32'hDEADBEEF, 17'd1, 32'h00000000});
      vecs.push_back('{1'b1, 1'b0, 32'd1028, 32'h00000000, 17'd1, 32'hDEADBEEF});
      vecs.push_back('{1'b1, 1'b1, 32'd1032, 32'h12345678, 17'd2, 32'hDEADBEEF});
      vecs.push_back('{1'b1, 1'b0, 32'd1032, 32'h00000000, 17'd2, 32'h12345678});
      vecs.push_back('{1'b0, 1'b1, 32'd1024, 32'hA5A50F0F, 17'd0, 32'h12345678});
      vecs.push_back('{1'b1, 1'b0, 32'd1024, 32'h00000000, 17'd0, 32'hA5A50F0F});
      vecs.push_back('{1'b1, 1'b0, 32'd1036, 32'h00000000, 17'd3, 32'h00000000});
`ifndef SRAM_BOUNDS_CHECK_EN
      // Low address bits are ignored and word indices wrap modulo 2^17.
      vecs.push_back('{1'b1, 1'b0, 32'd1030, 32'h00000000, 17'd1, 32'hDEADBEEF});
      vecs.push_back('{1'b1, 1'b0, 32'd525312, 32'h00000000, 17'd0, 32'hA5A50F0F});
`endif

      #1;
      check("rst_ready", {31'd0, ready}, 32'd1);
      check("rst_we_n", {31'd0, sram_we_n}, 32'd1);
      check("rst_oe", {31'd0, sram_dq_oe}, 32'd0);
      check("rst_read_data", read_data, 32'd0);
      check("rst_sram_addr", {14'd0, sram_addr}, 32'd0);
      #22;
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("idle_ready", {31'd0, ready}, 32'd1);
      check("idle_we_n", {31'd0, sram_we_n}, 32'd1);

      foreach (vecs[i]) run_vec(vecs[i]);

      // Reset during HIGH of STR 0xCAFEF00D @1040 (half-words 8 and 9).
      wr_en      = 1'b1;
      address    = 32'd1040;
      write_data = 32'hCAFEF00D;
      @(negedge clk);
      for (int c = 1; c <= W + 1; c++) begin
         @(posedge clk);
         @(negedge clk);
      end
      check("pre_rst_we_n", {31'd0, sram_we_n}, 32'd0);
      check("pre_rst_addr", {14'd0, sram_addr}, 32'd9);
      rst = 1'b1;
      #1;
      check("mid_rst_we_n", {31'd0, sram_we_n}, 32'd1);
      check("mid_rst_oe", {31'd0, sram_dq_oe}, 32'd0);
      check("mid_rst_addr", {14'd0, sram_addr}, 32'd0);
      check("mid_rst_read_data", read_data, 32'd0);
      wr_en = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check("post_rst_ready", {31'd0, ready}, 32'd1);
      @(posedge clk);
      #1;
      // Only the low half reached the SRAM before the reset.
      run_vec('{1'b1, 1'b0, 32'd1040, 32'h00000000, 17'd4, 32'h0000F00D});

`ifdef SRAM_BOUNDS_CHECK_EN
      for (int k = 0; k < 2; k++) begin
         rd_en   = 1'b1;
         address = (k == 0) ? 32'd512 : 32'd1030;
         @(negedge clk);
         check("err_req_ready", {31'd0, ready}, 32'd0);
         check("err_pre_flag", {31'd0, addr_err}, 32'd0);
         @(posedge clk);
         @(negedge clk);
         check("err_done_ready", {31'd0, ready}, 32'd1);
         check("err_flag", {31'd0, addr_err}, 32'd1);
         check("err_we_n", {31'd0, sram_we_n}, 32'd1);
         check("err_addr_hold", {14'd0, sram_addr}, 32'd9);
         check("err_read_data", read_data, 32'h0000F00D);
         rd_en = 1'b0;
         @(posedge clk);
         #1;
         check("err_flag_clear", {31'd0, addr_err}, 32'd0);
         check("err_idle_ready", {31'd0, ready}, 32'd1);
      end
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
